// File: rtl/multi_cycle_controller.sv
// Main control FSM of the multi-cycle MIPS core: sequences fetch, decode, execute,
// memory and writeback, and stalls on mem_ready for variable-latency memory.
module multi_cycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     cur;
    state_t     nxt;
    logic       funct_legal;
    logic [2:0] funct_alu;

    always_comb begin
        funct_legal = 1'b1;
        funct_alu   = ALU_ADD;
        case (funct)
            FN_ADD:  funct_alu = ALU_ADD;
            FN_SUB:  funct_alu = ALU_SUB;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            FN_SLT:  funct_alu = ALU_SLT;
            default: funct_legal = 1'b0;
        endcase
    end

    // Unrecognised opcodes/functs fall back to FETCH without any write state.
    always_comb begin
        nxt = FETCH;
        case (cur)
            FETCH:   nxt = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_RTYPE:     nxt = EXECUTE;
                    OP_BEQ:       nxt = BRANCH;
                    OP_ADDI:      nxt = ADDIEX;
                    OP_J:         nxt = JUMP;
                    default:      nxt = FETCH;
                endcase
            end
            MEMADR:  nxt = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   nxt = mem_ready ? MEMWB : MEMRD;
            MEMWB:   nxt = FETCH;
            MEMWR:   nxt = mem_ready ? FETCH : MEMWR;
            EXECUTE: nxt = funct_legal ? ALUWB : FETCH;
            ALUWB:   nxt = FETCH;
            BRANCH:  nxt = FETCH;
            ADDIEX:  nxt = ADDIWB;
            ADDIWB:  nxt = FETCH;
            JUMP:    nxt = FETCH;
            default: nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= FETCH;
        end else begin
            cur <= nxt;
        end
    end

    // Moore decode; the FETCH strobes are additionally gated by rst_n so that
    // nothing is loaded while reset is held even if mem_ready is high.
    always_comb begin
        iord        = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        pc_src      = 2'b00;
        pc_en       = 1'b0;
        case (cur)
            FETCH: begin
                alu_src_b = 2'b01;
                ir_write  = mem_ready & rst_n;
                pc_en     = mem_ready & rst_n;
            end
            DECODE: begin
                alu_src_b = 2'b11;
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD: begin
                iord = 1'b1;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            EXECUTE: begin
                alu_src_a   = 1'b1;
                alu_control = funct_alu;
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_src      = 2'b01;
                pc_en       = zero;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            ADDIWB: begin
                reg_write = 1'b1;
            end
            JUMP: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
            end
            default: begin
                alu_control = ALU_ADD;
            end
        endcase
    end

    assign state = cur;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed scoreboard bench for multi_cycle_controller: each cycle pushes the expected
// state/outputs, which are popped and compared at the following falling edge.
module tb_multi_cycle_controller;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_BAD = 6'b000000;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] pc_src;
    logic       pc_en;
    logic [3:0] state;

    typedef struct packed {
        logic [3:0]  st;
        logic [14:0] outs;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    multi_cycle_controller dut (
        .clk(clk),
        .rst_n(rst_n),
        .op(op),
        .funct(funct),
        .zero(zero),
        .mem_ready(mem_ready),
        .iord(iord),
        .mem_write(mem_write),
        .ir_write(ir_write),
        .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg),
        .reg_write(reg_write),
        .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b),
        .alu_control(alu_control),
        .pc_src(pc_src),
        .pc_en(pc_en),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packing: iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
    // alu_src_a, alu_src_b[1:0], alu_control[2:0], pc_src[1:0], pc_en
    function automatic logic [14:0] expOuts(input logic [3:0] st, input logic mr,
                                            input logic z, input logic [5:0] fn);
        logic       e_iord = 0, e_mw = 0, e_irw = 0, e_rd = 0, e_m2r = 0, e_rw = 0, e_a = 0, e_pe = 0;
        logic [1:0] e_b = 2'b00, e_ps = 2'b00;
        logic [2:0] e_alu = 3'b010;
        case (st)
            4'd0: begin e_b = 2'b01; e_irw = mr; e_pe = mr; end
            4'd1: e_b = 2'b11;
            4'd2: begin e_a = 1; e_b = 2'b10; end
            4'd3: e_iord = 1;
            4'd4: begin e_rw = 1; e_m2r = 1; end
            4'd5: begin e_iord = 1; e_mw = 1; end
            4'd6: begin
                e_a = 1;
                if (fn == 6'b100010) e_alu = 3'b110;
                else if (fn == 6'b100100) e_alu = 3'b000;
                else if (fn == 6'b100101) e_alu = 3'b001;
                else if (fn == 6'b101010) e_alu = 3'b111;
            end
            4'd7: begin e_rw = 1; e_rd = 1; end
            4'd8: begin e_a = 1; e_alu = 3'b110; e_ps = 2'b01; e_pe = z; end
            4'd9: begin e_a = 1; e_b = 2'b10; end
            4'd10: e_rw = 1;
            4'd11: begin e_ps = 2'b10; e_pe = 1; end
            default: ;
        endcase
        return {e_iord, e_mw, e_irw, e_rd, e_m2r, e_rw, e_a, e_b, e_alu, e_ps, e_pe};
    endfunction

    task automatic checkOutput(input string tag);
        exp_t        e;
        logic [14:0] got;
        e = sb.pop_front();
        got = {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_control, pc_src, pc_en};
        checks++;
        assert (state === e.st) else begin
            errors++;
            $error("[TB] FAIL %s state got %0d want %0d", tag, state, e.st);
        end
        checks++;
        assert (got === e.outs) else begin
            errors++;
            $error("[TB] FAIL %s outputs got %b want %b", tag, got, e.outs);
        end
    endtask

    // Drives one cycle of inputs, queues the expectation for the current state,
    // checks at the falling edge and returns just after the next rising edge.
    task automatic applyStimulus(input string tag, input logic [3:0] st, input logic [5:0] o,
                                 input logic [5:0] f, input logic z, input logic mr);
        exp_t e;
        op = o;
        funct = f;
        zero = z;
        mem_ready = mr;
        e.st = st;
        e.outs = expOuts(st, mr, z, f);
        sb.push_back(e);
        @(negedge clk);
        checkOutput(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        op = OP_LW;
        funct = FN_ADD;
        zero = 1'b0;
        mem_ready = 1'b1;
        #1 rst_n = 1'b0;

        // reset: FETCH decode with strobes forced low although mem_ready=1
        sb.push_back('{st: 4'd0, outs: expOuts(4'd0, 1'b0, 1'b0, FN_ADD)});
        @(negedge clk);
        checkOutput("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        applyStimulus("lw_fetch",  4'd0, OP_LW, FN_ADD, 0, 1);
        applyStimulus("lw_decode", 4'd1, OP_LW, FN_ADD, 0, 1);
        applyStimulus("lw_memadr", 4'd2, OP_LW, FN_ADD, 0, 1);
        applyStimulus("lw_memrd",  4'd3, OP_LW, FN_ADD, 0, 1);
        applyStimulus("lw_memwb",  4'd4, OP_LW, FN_ADD, 0, 1);

        applyStimulus("add_fetch", 4'd0, OP_R, FN_ADD, 0, 1);
        applyStimulus("add_dec",   4'd1, OP_R, FN_ADD, 0, 1);
        applyStimulus("add_exe",   4'd6, OP_R, FN_ADD, 0, 1);
        applyStimulus("add_wb",    4'd7, OP_R, FN_ADD, 0, 1);
        applyStimulus("or_fetch",  4'd0, OP_R, FN_OR, 0, 1);
        applyStimulus("or_dec",    4'd1, OP_R, FN_OR, 0, 1);
        applyStimulus("or_exe",    4'd6, OP_R, FN_OR, 0, 1);
        applyStimulus("or_wb",     4'd7, OP_R, FN_OR, 0, 1);
        applyStimulus("slt_fetch", 4'd0, OP_R, FN_SLT, 0, 1);
        applyStimulus("slt_dec",   4'd1, OP_R, FN_SLT, 0, 1);
        applyStimulus("slt_exe",   4'd6, OP_R, FN_SLT, 0, 1);
        applyStimulus("slt_wb",    4'd7, OP_R, FN_SLT, 0, 1);
        applyStimulus("sub_fetch", 4'd0, OP_R, FN_SUB, 0, 1);
        applyStimulus("sub_dec",   4'd1, OP_R, FN_SUB, 0, 1);
        applyStimulus("sub_exe",   4'd6, OP_R, FN_SUB, 0, 1);
        applyStimulus("sub_wb",    4'd7, OP_R, FN_SUB, 0, 1);

        applyStimulus("beq1_fetch", 4'd0, OP_BEQ, FN_ADD, 1, 1);
        applyStimulus("beq1_dec",   4'd1, OP_BEQ, FN_ADD, 1, 1);
        applyStimulus("beq1_br",    4'd8, OP_BEQ, FN_ADD, 1, 1);
        applyStimulus("beq0_fetch", 4'd0, OP_BEQ, FN_ADD, 0, 1);
        applyStimulus("beq0_dec",   4'd1, OP_BEQ, FN_ADD, 0, 1);
        applyStimulus("beq0_br",    4'd8, OP_BEQ, FN_ADD, 0, 1);

        applyStimulus("sw_fetch",   4'd0, OP_SW, FN_ADD, 0, 1);
        applyStimulus("sw_dec",     4'd1, OP_SW, FN_ADD, 0, 1);
        applyStimulus("sw_memadr",  4'd2, OP_SW, FN_ADD, 0, 1);
        applyStimulus("sw_wait1",   4'd5, OP_SW, FN_ADD, 0, 0);
        applyStimulus("sw_wait2",   4'd5, OP_SW, FN_ADD, 0, 0);
        applyStimulus("sw_wait3",   4'd5, OP_SW, FN_ADD, 0, 0);
        applyStimulus("sw_done",    4'd5, OP_SW, FN_ADD, 0, 1);
        applyStimulus("fetch_hold1", 4'd0, OP_J, FN_ADD, 0, 0);
        applyStimulus("fetch_hold2", 4'd0, OP_J, FN_ADD, 0, 0);
        applyStimulus("j_fetch",    4'd0, OP_J, FN_ADD, 0, 1);
        applyStimulus("j_dec",      4'd1, OP_J, FN_ADD, 0, 1);
        applyStimulus("j_jump",     4'd11, OP_J, FN_ADD, 0, 1);

        applyStimulus("lwwait_fetch", 4'd0, OP_LW, FN_ADD, 0, 1);
        applyStimulus("lwwait_dec",   4'd1, OP_LW, FN_ADD, 0, 1);
        applyStimulus("lwwait_adr",   4'd2, OP_LW, FN_ADD, 0, 1);
        applyStimulus("lwwait_rd0",   4'd3, OP_LW, FN_ADD, 0, 0);
        applyStimulus("lwwait_rd1",   4'd3, OP_LW, FN_ADD, 0, 1);
        applyStimulus("lwwait_wb",    4'd4, OP_LW, FN_ADD, 0, 1);

        applyStimulus("addi_fetch", 4'd0, OP_ADDI, FN_ADD, 0, 1);
        applyStimulus("addi_dec",   4'd1, OP_ADDI, FN_ADD, 0, 1);
        applyStimulus("addi_ex",    4'd9, OP_ADDI, FN_ADD, 0, 1);
        applyStimulus("addi_wb",    4'd10, OP_ADDI, FN_ADD, 0, 1);

        applyStimulus("bad_fetch",  4'd0, OP_BAD, FN_ADD, 0, 1);
        applyStimulus("bad_dec",    4'd1, OP_BAD, FN_ADD, 0, 1);
        applyStimulus("badfn_fetch", 4'd0, OP_R, FN_BAD, 0, 1);
        applyStimulus("badfn_dec",   4'd1, OP_R, FN_BAD, 0, 1);
        applyStimulus("badfn_exe",   4'd6, OP_R, FN_BAD, 0, 1);
        applyStimulus("badfn_back",  4'd0, OP_LW, FN_ADD, 0, 1);

        // lw up to MEMWB, then reset asynchronously between clock edges
        applyStimulus("rlw_dec",    4'd1, OP_LW, FN_ADD, 0, 1);
        applyStimulus("rlw_adr",    4'd2, OP_LW, FN_ADD, 0, 1);
        applyStimulus("rlw_rd",     4'd3, OP_LW, FN_ADD, 0, 1);
        sb.push_back('{st: 4'd4, outs: expOuts(4'd4, 1'b1, 1'b0, FN_ADD)});
        @(negedge clk);
        checkOutput("rlw_wb");
        #2 rst_n = 1'b0;
        #1;
        checks++;
        assert (state === 4'd0) else begin
            errors++;
            $error("[TB] FAIL async_rst state got %0d want 0", state);
        end
        checks++;
        assert (reg_write === 1'b0) else begin
            errors++;
            $error("[TB] FAIL async_rst reg_write got %b want 0", reg_write);
        end
        checks++;
        assert ({ir_write, pc_en} === 2'b00) else begin
            errors++;
            $error("[TB] FAIL async_rst ir_write/pc_en got %b want 00", {ir_write, pc_en});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        applyStimulus("post_fetch", 4'd0, OP_ADDI, FN_ADD, 0, 1);
        applyStimulus("post_dec",   4'd1, OP_ADDI, FN_ADD, 0, 1);
        applyStimulus("post_ex",    4'd9, OP_ADDI, FN_ADD, 0, 1);
        applyStimulus("post_wb",    4'd10, OP_ADDI, FN_ADD, 0, 1);
        applyStimulus("post_idle",  4'd0, OP_ADDI, FN_ADD, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_cycle_controller.md
Name: multi_cycle_controller

Overview:
- Main control FSM of the multi-cycle MIPS core; sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the register file write strobe and the write-address/write-data selects (reg_dst, mem_to_reg).
- Drives PC, IR, ALU and memory controls, and adds a mem_ready handshake for variable-latency memory.
- Opcode and funct come from the instruction register.

Parameters:
- none. Encodings below are fixed.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- op  input  6  instr[31:26] from IR
- funct  input  6  instr[5:0] from IR
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory access complete this cycle
- iord  output  1  memory address select: 0=PC, 1=ALUOut
- mem_write  output  1  memory write strobe
- ir_write  output  1  IR load enable
- reg_dst  output  1  register write address: 0=rt, 1=rd
- mem_to_reg  output  1  register write data: 0=ALUOut, 1=Data reg
- reg_write  output  1  register file write enable (we3)
- alu_src_a  output  1  ALU A: 0=PC, 1=A reg
- alu_src_b  output  2  ALU B: 00=B reg, 01=const 4, 10=SignImm, 11=SignImm<<2
- alu_control  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- pc_src  output  2  PC source: 00=ALUResult, 01=ALUOut, 10=jump target
- pc_en  output  1  PC load enable = pc_write | (branch & zero)
- state  output  4  current state, for debug

Behaviour:
- Moore FSM; outputs decode combinationally from state. Exceptions: ir_write/pc_en in FETCH depend on mem_ready, and pc_en in BRANCH depends on zero.
- Any output not listed for a state is 0. alu_control defaults to 010.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010.
- Functs: add=100000, sub=100010, and=100100, or=100101, slt=101010.
- FETCH: alu_src_b=01, add. ir_write=pc_write=mem_ready. Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE: alu_src_b=11, add (precomputes branch target).
  - lw/sw -> MEMADR; R -> EXECUTE; beq -> BRANCH; addi -> ADDIEX; j -> JUMP.
  - Any other opcode -> FETCH; no architectural write occurs.
- MEMADR: alu_src_a=1, alu_src_b=10, add. lw -> MEMRD; otherwise -> MEMWR.
- MEMRD: iord=1. Holds until mem_ready, then -> MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
- MEMWR: iord=1, mem_write=1, held continuously while waiting. When mem_ready -> FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_control from funct.
  - Legal funct -> ALUWB.
  - Unknown funct -> FETCH; no register write.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01, pc_en=zero -> FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, add -> ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
- JUMP: pc_src=10, pc_en=1 -> FETCH.
- Illegal states 12-15: next state FETCH; all strobes 0.
- Instruction latency with mem_ready tied high:
  - lw 5 cycles; R-type, sw and addi 4; beq and j 3.
  - Each memory wait cycle adds 1.
- Writes to r0 are issued normally; register 0 is handled downstream.
- Reset: asserting rst_n=0 forces state=FETCH immediately, regardless of clk.
  - While rst_n=0, ir_write, pc_en, reg_write and mem_write are forced 0.
  - Other outputs show the FETCH decode.
  - Reset mid-instruction abandons it; no partial write occurs after the reset edge.
- First rising clk edge after rst_n rises evaluates FETCH normally.

Test Plan:
- Reset, mem_ready=1, op=lw:
  - State sequence 0,1,2,3,4,0.
  - reg_write=1 and mem_to_reg=1 only in state 4.
  - ir_write and pc_en high only in the FETCH cycle.
- R-type add, then or, then slt (funct 100000/100101/101010):
  - alu_control 010/001/111 in EXECUTE.
  - ALUWB has reg_dst=1 and reg_write=1.
  - 4 cycles per instruction.
- beq with zero=1, then zero=0:
  - BRANCH has pc_src=01, alu_control=110.
  - pc_en=1 first case, 0 second.
  - Both return to FETCH after 3 cycles.
- sw with mem_ready low 3 cycles in MEMWR:
  - mem_write and iord stay 1 for 4 cycles, then FETCH.
  - FETCH with mem_ready low holds, with ir_write=0.
- Illegal op=111111 in DECODE -> FETCH next cycle, no write strobe.
  - R-type with funct=000000 -> EXECUTE, then FETCH, with reg_write never 1.
- Deassert rst_n asynchronously while in MEMWB (mid-clock):
  - state=0 and reg_write=0 immediately.
  - After release, FETCH proceeds normally.
